// File: rtl/game_setup_loader_if.sv
// Request and config-write bundle between the menu FSM, the setup loader and the settings bank.
// The loader drives through the master modport; the menu/bank side uses slave.
interface game_setup_loader_if #(
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic [1:0]        req_level;
    logic              req_ready;
    logic              cfg_wr_valid;
    logic [2:0]        cfg_wr_addr;
    logic [DATA_W-1:0] cfg_wr_data;
    logic              cfg_wr_ready;
    logic              busy;
    logic              cfg_done;
    logic              cfg_error;
    logic [1:0]        cur_level;

    modport master (
        input  req_valid, req_level, cfg_wr_ready,
        output req_ready, cfg_wr_valid, cfg_wr_addr, cfg_wr_data,
               busy, cfg_done, cfg_error, cur_level
    );

    modport slave (
        output req_valid, req_level, cfg_wr_ready,
        input  req_ready, cfg_wr_valid, cfg_wr_addr, cfg_wr_data,
               busy, cfg_done, cfg_error, cur_level
    );
endinterface

// File: rtl/game_setup_loader.sv
// Streams the seven per-level setup words into the game-settings bank on a menu request,
// then pulses cfg_done; illegal level 3 only pulses cfg_error.
module game_setup_loader #(
    parameter int X_CENTER = 512,
    parameter int Y_CENTER = 384,
    parameter int DATA_W   = 16
) (
    input logic clk,
    input logic rst,
    game_setup_loader_if.master bus
);
    localparam int FIELD = 64;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t     state, state_nx;
    logic [1:0] level_q;
    logic [1:0] cur_level_q;
    logic [2:0] addr_q;
    logic       error_q;

    // Every operand is an elaboration constant for a given level/addr, so this folds to a ROM.
    function automatic logic [DATA_W-1:0] setup_word(input logic [1:0] lvl, input logic [2:0] a);
        logic signed [DATA_W-1:0] rows, mines, secs, size, half;
        case (lvl)
            2'd1:    begin rows = DATA_W'(10); mines = DATA_W'(30); secs = DATA_W'(50); end
            2'd2:    begin rows = DATA_W'(15); mines = DATA_W'(40); secs = DATA_W'(70); end
            default: begin rows = DATA_W'(8);  mines = DATA_W'(19); secs = DATA_W'(45); end
        endcase
        size = DATA_W'(FIELD) * rows;
        half = size >>> 1;
        case (a)
            3'd0:    setup_word = rows;
            3'd1:    setup_word = mines;
            3'd2:    setup_word = secs;
            3'd3:    setup_word = DATA_W'(FIELD);
            3'd4:    setup_word = size;
            3'd5:    setup_word = DATA_W'(X_CENTER) - half;
            3'd6:    setup_word = DATA_W'(Y_CENTER) - half;
            default: setup_word = '0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.req_valid && bus.req_level != 2'd3) state_nx = LOAD;
            LOAD: if (bus.cfg_wr_ready && addr_q == 3'd6)     state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q     <= '0;
            cur_level_q <= '0;
            addr_q      <= '0;
            error_q     <= 1'b0;
        end else begin
            error_q <= (state == IDLE) && bus.req_valid && (bus.req_level == 2'd3);
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_level != 2'd3) begin
                        level_q <= bus.req_level;
                        addr_q  <= '0;
                    end
                end
                LOAD: begin
                    if (bus.cfg_wr_ready) begin
                        if (addr_q == 3'd6) begin
                            addr_q      <= '0;
                            cur_level_q <= level_q;
                        end else begin
                            addr_q <= addr_q + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.req_ready    = (state == IDLE);
        bus.cfg_wr_valid = (state == LOAD);
        bus.cfg_wr_addr  = addr_q;
        bus.cfg_wr_data  = (state == LOAD) ? setup_word(level_q, addr_q) : '0;
        bus.busy         = (state != IDLE);
        bus.cfg_done     = (state == DONE);
        bus.cfg_error    = error_q;
        bus.cur_level    = cur_level_q;
    end
endmodule

// File: tb/tb_game_setup_loader.sv
// Self-checking bench: queue-based reference of expected write beats, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_game_setup_loader;
    localparam int DW = 16;
    localparam int XC = 512;
    localparam int YC = 384;

    typedef logic [15:0] words_t [7];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    game_setup_loader_if #(.DATA_W(DW)) bus();

    game_setup_loader #(.X_CENTER(XC), .Y_CENTER(YC), .DATA_W(DW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Setup words from the game rules: board = 64 * rows, position = centre - board/2.
    function automatic logic [15:0] exp_word(input int lvl, input int a);
        int rows, mines, secs, size;
        case (lvl)
            1:       begin rows = 10; mines = 30; secs = 50; end
            2:       begin rows = 15; mines = 40; secs = 70; end
            default: begin rows = 8;  mines = 19; secs = 45; end
        endcase
        size = 64 * rows;
        case (a)
            0:       return 16'(rows);
            1:       return 16'(mines);
            2:       return 16'(secs);
            3:       return 16'(64);
            4:       return 16'(size);
            5:       return 16'(XC - size / 2);
            6:       return 16'(YC - size / 2);
            default: return 16'(0);
        endcase
    endfunction

    // Reference: outstanding beats queue plus one-cycle done/error flags.
    int          mq_addr[$];
    logic [15:0] mq_data[$];
    bit          m_done = 0;
    bit          m_err  = 0;
    logic [1:0]  m_cur  = 2'd0;
    logic [1:0]  m_pend = 2'd0;
    bit          nd, ne;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq_addr.delete();
            mq_data.delete();
            m_done = 0;
            m_err  = 0;
            m_cur  = 2'd0;
            m_pend = 2'd0;
        end else begin
            nd = 0;
            ne = 0;
            if (mq_addr.size() > 0) begin
                if (bus.cfg_wr_ready) begin
                    void'(mq_addr.pop_front());
                    void'(mq_data.pop_front());
                    if (mq_addr.size() == 0) begin
                        nd    = 1;
                        m_cur = m_pend;
                    end
                end
            end else if (!m_done && bus.req_valid) begin
                if (bus.req_level == 2'd3) begin
                    ne = 1;
                end else begin
                    m_pend = bus.req_level;
                    for (int a = 0; a < 7; a++) begin
                        mq_addr.push_back(a);
                        mq_data.push_back(exp_word(int'(bus.req_level), a));
                    end
                end
            end
            m_done = nd;
            m_err  = ne;
        end
    end

    always @(negedge clk) begin
        chk("req_ready", bus.req_ready, (mq_addr.size() == 0) && !m_done);
        chk("wr_valid", bus.cfg_wr_valid, mq_addr.size() > 0);
        if (mq_addr.size() > 0 && bus.cfg_wr_valid) begin
            chk("wr_addr", bus.cfg_wr_addr, mq_addr[0]);
            chk("wr_data", bus.cfg_wr_data, mq_data[0]);
        end
        chk("busy", bus.busy, (mq_addr.size() > 0) || m_done);
        chk("cfg_done", bus.cfg_done, m_done);
        chk("cfg_error", bus.cfg_error, m_err);
        chk("cur_level", bus.cur_level, m_cur);
    end

    logic [15:0] log_q[$];
    always @(negedge clk) begin
        if (!rst && bus.cfg_wr_valid && bus.cfg_wr_ready) log_q.push_back(bus.cfg_wr_data);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 1);
        chk({tag, "_wr_valid"}, bus.cfg_wr_valid, 0);
        chk({tag, "_wr_addr"}, bus.cfg_wr_addr, 0);
        chk({tag, "_wr_data"}, bus.cfg_wr_data, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.cfg_done, 0);
        chk({tag, "_error"}, bus.cfg_error, 0);
        chk({tag, "_cur_level"}, bus.cur_level, 0);
    endtask

    task automatic chk_log(input string tag, input words_t e);
        chk({tag, "_beats"}, log_q.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < log_q.size()) chk({tag, "_beat"}, log_q[i], e[i]);
        end
    endtask

    // Issues one request from IDLE; ready follows pat[(k-1)%4] in cycle k after acceptance.
    task automatic run_load(input logic [1:0] lvl, input logic [3:0] pat, output int done_at);
        log_q.delete();
        bus.req_valid = 1'b1;
        bus.req_level = lvl;
        @(posedge clk);
        #2;
        bus.req_valid    = 1'b0;
        bus.cfg_wr_ready = pat[0];
        done_at = -1;
        for (int k = 1; k <= 60 && done_at < 0; k++) begin
            @(negedge clk);
            if (bus.cfg_done) done_at = k;
            @(posedge clk);
            #2;
            bus.cfg_wr_ready = pat[k % 4];
        end
        if (done_at < 0) chk("load_timeout", 0, 1);
    endtask

    words_t e_easy = '{16'd8, 16'd19, 16'd45, 16'd64, 16'd512, 16'd256, 16'd128};
    words_t e_med  = '{16'd10, 16'd30, 16'd50, 16'd64, 16'd640, 16'd192, 16'd64};
    words_t e_hard = '{16'd15, 16'd40, 16'd70, 16'd64, 16'd960, 16'd32, 16'hFFA0};

    initial begin
        int d;
        bit found;
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_level    = 2'd0;
        bus.cfg_wr_ready = 1'b0;
        repeat (3) step();
        chk_reset_vals("rst");
        rst = 1'b0;
        step();

        run_load(2'd0, 4'b1111, d);
        chk("easy_done_cycle", d, 8);
        chk_log("easy", e_easy);
        chk("easy_cur", bus.cur_level, 0);

        run_load(2'd2, 4'b1111, d);
        chk("hard_done_cycle", d, 8);
        chk_log("hard", e_hard);
        chk("hard_cur", bus.cur_level, 2);

        run_load(2'd1, 4'b1001, d);
        chk("med_done_cycle", d, 14);
        chk_log("med", e_med);
        chk("med_cur", bus.cur_level, 1);

        // Illegal level: single error pulse, no beats, nothing else moves.
        log_q.delete();
        bus.req_valid = 1'b1;
        bus.req_level = 2'd3;
        @(posedge clk);
        #2;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("ill_error", bus.cfg_error, 1);
        chk("ill_ready", bus.req_ready, 1);
        chk("ill_cur", bus.cur_level, 1);
        step();
        @(negedge clk);
        chk("ill_error_clr", bus.cfg_error, 0);
        repeat (3) step();
        chk("ill_beats", log_q.size(), 0);

        // Request held through a load is taken again right after cfg_done.
        log_q.delete();
        bus.cfg_wr_ready = 1'b1;
        bus.req_valid    = 1'b1;
        bus.req_level    = 2'd0;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #2;
        bus.req_valid = 1'b0;
        repeat (12) step();
        chk("held_beats", log_q.size(), 14);
        if (log_q.size() > 7) chk("held_restart", log_q[7], 16'd8);

        // Reset at beat 3 aborts immediately.
        bus.req_valid = 1'b1;
        bus.req_level = 2'd2;
        @(posedge clk);
        #2;
        bus.req_valid = 1'b0;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus.cfg_wr_valid && bus.cfg_wr_addr == 3'd3) found = 1;
        end
        chk("abort_found_addr3", found, 1);
        #1 rst = 1'b1;
        #1 chk_reset_vals("abort");
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (10) step();
        run_load(2'd0, 4'b1111, d);
        chk("after_abort_done_cycle", d, 8);
        chk_log("after_abort", e_easy);

        // Random traffic; the reference follows every cycle.
        for (int c = 0; c < 3000; c++) begin
            bus.cfg_wr_ready = ($urandom_range(0, 3) != 0);
            bus.req_valid    = ($urandom_range(0, 2) == 0);
            bus.req_level    = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            step();
        end
        bus.req_valid = 1'b0;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
